// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller: decoded micro-op payload and widths.
package alu_issue_ctrl_pkg;

  localparam int unsigned GPR_IDX_W = 4;
  localparam int unsigned OPCODE_W  = 10;
  localparam int unsigned XLEN      = 64;

  typedef logic [OPCODE_W-1:0]  opcode_t;
  typedef logic [GPR_IDX_W-1:0] gpr_idx_t;

  // Decoded micro-op as buffered between decode and the ALU.
  typedef struct packed {
    opcode_t         opcode;
    gpr_idx_t        src1;
    gpr_idx_t        src2;
    gpr_idx_t        dst;
    logic            src1_v;
    logic            src2_v;
    logic            dst_v;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] next_rip;
  } uop_t;

endpackage

// File: rtl/alu_issue_ctrl_uop_fifo.sv
// Micro-op FIFO with synchronous flush.
// Ports: clk, reset_n (async active-low), flush (drops contents and any
// same-cycle push), push/push_data, pop, head (valid when !empty), full, empty.
module alu_issue_ctrl_uop_fifo
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic flush,
  input  logic push,
  input  uop_t push_data,
  input  logic pop,
  output uop_t head,
  output logic full,
  output logic empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  uop_t             mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign head  = mem[rd_ptr[IDX_W-1:0]];

  // Pointer update; flush has priority over push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: buffers micro-ops, tracks pending GPR writes
// in a scoreboard, issues one hazard-free micro-op per cycle to the ALU and
// turns a taken branch into a flush plus a one-cycle fetch redirect.
// Ports: decode input (in_*), in_ready; regfile read indices rf_rd1/rf_rd2
// (combinational); registered ALU issue (alu_*); mem_blocked stall;
// writeback retire (wb_*); branch resolve (branch_*); redirect pulse and
// address; busy_mask debug view of the scoreboard.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NREGS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPCODE_W-1:0]  in_opcode,
  input  logic [GPR_IDX_W-1:0] in_src1,
  input  logic [GPR_IDX_W-1:0] in_src2,
  input  logic [GPR_IDX_W-1:0] in_dst,
  input  logic                 in_src1_v,
  input  logic                 in_src2_v,
  input  logic                 in_dst_v,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [XLEN-1:0]      in_next_rip,
  output logic [GPR_IDX_W-1:0] rf_rd1,
  output logic [GPR_IDX_W-1:0] rf_rd2,
  output logic                 alu_enable,
  output logic [OPCODE_W-1:0]  alu_opcode,
  output logic [GPR_IDX_W-1:0] alu_dst,
  output logic                 alu_dst_v,
  output logic [XLEN-1:0]      alu_imm,
  output logic [XLEN-1:0]      alu_next_rip,
  input  logic                 mem_blocked,
  input  logic                 wb_valid,
  input  logic [GPR_IDX_W-1:0] wb_dst,
  input  logic                 branch_taken,
  input  logic [XLEN-1:0]      branch_target,
  output logic                 redirect,
  output logic [XLEN-1:0]      redirect_rip,
  output logic [NREGS-1:0]     busy_mask
);

  uop_t             in_uop;
  uop_t             head;
  logic             full;
  logic             empty;
  logic             hazard;
  logic             can_issue;
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;

  assign in_uop = '{
    opcode:   in_opcode,
    src1:     in_src1,
    src2:     in_src2,
    dst:      in_dst,
    src1_v:   in_src1_v,
    src2_v:   in_src2_v,
    dst_v:    in_dst_v,
    imm:      in_imm,
    next_rip: in_next_rip
  };

  alu_issue_ctrl_uop_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (branch_taken),
    .push      (in_valid),
    .push_data (in_uop),
    .pop       (can_issue),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign in_ready  = !full;
  assign rf_rd1    = empty ? '0 : head.src1;
  assign rf_rd2    = empty ? '0 : head.src2;
  assign busy_mask = busy;

  // RAW on either source plus WAW on the destination; no writeback bypass.
  assign hazard = (head.src1_v && busy[head.src1]) ||
                  (head.src2_v && busy[head.src2]) ||
                  (head.dst_v  && busy[head.dst]);

  assign can_issue = !empty && !hazard && !mem_blocked && !branch_taken;

  // Scoreboard next state; the issue set is applied last so it wins a tie.
  always_comb begin
    busy_next = busy;
    if (wb_valid)                 busy_next[wb_dst]   = 1'b0;
    if (can_issue && head.dst_v)  busy_next[head.dst] = 1'b1;
  end

  // Scoreboard, ALU issue registers and redirect pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy         <= '0;
      alu_enable   <= 1'b0;
      alu_opcode   <= '0;
      alu_dst      <= '0;
      alu_dst_v    <= 1'b0;
      alu_imm      <= '0;
      alu_next_rip <= '0;
      redirect     <= 1'b0;
      redirect_rip <= '0;
    end else begin
      busy       <= busy_next;
      alu_enable <= can_issue;
      redirect   <= branch_taken;
      if (can_issue) begin
        alu_opcode   <= head.opcode;
        alu_dst      <= head.dst;
        alu_dst_v    <= head.dst_v;
        alu_imm      <= head.imm;
        alu_next_rip <= head.next_rip;
      end
      if (branch_taken) redirect_rip <= branch_target;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios followed by
// random traffic, compared each cycle against a queue-based reference model.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_opcode;
  logic [3:0]  in_src1, in_src2, in_dst;
  logic        in_src1_v, in_src2_v, in_dst_v;
  logic [63:0] in_imm, in_next_rip;
  logic [3:0]  rf_rd1, rf_rd2;
  logic        alu_enable;
  logic [9:0]  alu_opcode;
  logic [3:0]  alu_dst;
  logic        alu_dst_v;
  logic [63:0] alu_imm, alu_next_rip;
  logic        mem_blocked;
  logic        wb_valid;
  logic [3:0]  wb_dst;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        redirect;
  logic [63:0] redirect_rip;
  logic [15:0] busy_mask;

  alu_issue_ctrl #(.DEPTH(DEPTH), .NREGS(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst),
    .in_src1_v(in_src1_v), .in_src2_v(in_src2_v), .in_dst_v(in_dst_v),
    .in_imm(in_imm), .in_next_rip(in_next_rip),
    .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_dst(alu_dst),
    .alu_dst_v(alu_dst_v), .alu_imm(alu_imm), .alu_next_rip(alu_next_rip),
    .mem_blocked(mem_blocked), .wb_valid(wb_valid), .wb_dst(wb_dst),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .redirect(redirect), .redirect_rip(redirect_rip), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model state
  uop_t        q[$];
  logic [15:0] m_busy;
  logic        e_en;
  uop_t        e_pay;
  logic        e_redir;
  logic [63:0] e_rip;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_busy  = '0;
    e_en    = 1'b0;
    e_pay   = '0;
    e_redir = 1'b0;
    e_rip   = '0;
  endtask

  task automatic idle();
    in_valid = 0; in_opcode = '0; in_src1 = '0; in_src2 = '0; in_dst = '0;
    in_src1_v = 0; in_src2_v = 0; in_dst_v = 0; in_imm = '0; in_next_rip = '0;
    wb_valid = 0; wb_dst = '0; branch_taken = 0; branch_target = '0;
  endtask

  task automatic drive_uop(input logic [9:0] op, input logic [3:0] s1, input logic s1v,
                           input logic [3:0] s2, input logic s2v,
                           input logic [3:0] d, input logic dv, input logic [63:0] imm);
    in_valid = 1; in_opcode = op;
    in_src1 = s1; in_src1_v = s1v; in_src2 = s2; in_src2_v = s2v;
    in_dst = d; in_dst_v = dv; in_imm = imm; in_next_rip = imm + 64'h4;
  endtask

  // One cycle: inputs already applied (after negedge). Checks combinational
  // outputs, advances the model, then checks registered outputs after posedge.
  task automatic tick();
    logic       blocked;
    logic       go;
    logic       accept;
    uop_t       iu;
    #1;
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check("rf_rd1", 64'(rf_rd1), 64'(q.size() > 0 ? q[0].src1 : 4'd0));
    check("rf_rd2", 64'(rf_rd2), 64'(q.size() > 0 ? q[0].src2 : 4'd0));
    blocked = 1'b0;
    if (q.size() > 0)
      blocked = (q[0].src1_v && m_busy[q[0].src1]) || (q[0].src2_v && m_busy[q[0].src2]) ||
                (q[0].dst_v && m_busy[q[0].dst]);
    go     = (q.size() > 0) && !blocked && !mem_blocked && !branch_taken;
    accept = in_valid && (q.size() < DEPTH) && !branch_taken;
    iu = '{opcode: in_opcode, src1: in_src1, src2: in_src2, dst: in_dst,
           src1_v: in_src1_v, src2_v: in_src2_v, dst_v: in_dst_v,
           imm: in_imm, next_rip: in_next_rip};
    if (wb_valid) m_busy[wb_dst] = 1'b0;
    e_en = go;
    if (go) begin
      e_pay = q.pop_front();
      if (e_pay.dst_v) m_busy[e_pay.dst] = 1'b1;
    end
    if (branch_taken) q.delete();
    else if (accept) q.push_back(iu);
    e_redir = branch_taken;
    if (branch_taken) e_rip = branch_target;
    @(posedge clk);
    #1;
    check("alu_enable", 64'(alu_enable), 64'(e_en));
    check("alu_opcode", 64'(alu_opcode), 64'(e_pay.opcode));
    check("alu_dst", 64'(alu_dst), 64'(e_pay.dst));
    check("alu_dst_v", 64'(alu_dst_v), 64'(e_pay.dst_v));
    check("alu_imm", alu_imm, e_pay.imm);
    check("alu_next_rip", alu_next_rip, e_pay.next_rip);
    check("busy_mask", 64'(busy_mask), 64'(m_busy));
    check("redirect", 64'(redirect), 64'(e_redir));
    check("redirect_rip", redirect_rip, e_rip);
    @(negedge clk);
  endtask

  task automatic clear_all();
    idle(); mem_blocked = 0;
    for (int r = 0; r < 16; r++) begin
      wb_valid = 1; wb_dst = 4'(r); tick();
    end
    idle();
    repeat (6) tick();
    for (int r = 0; r < 16; r++) begin
      wb_valid = 1; wb_dst = 4'(r); tick();
    end
    idle();
  endtask

  initial begin
    idle(); mem_blocked = 0;
    reset_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_alu_enable", 64'(alu_enable), 64'd0);
    check("rst_redirect", 64'(redirect), 64'd0);
    check("rst_busy", 64'(busy_mask), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_alu_imm", alu_imm, 64'd0);
    reset_n = 1;

    // ADD r3 <- r1, r2: issues two cycles after the push
    drive_uop(10'h001, 4'd1, 1, 4'd2, 1, 4'd3, 1, 64'h1000); tick();
    idle();
    check("add_not_yet", 64'(alu_enable), 64'd0);
    tick();
    check("add_issue", 64'(alu_enable), 64'd1);
    check("add_dst", 64'(alu_dst), 64'd3);
    check("add_busy", 64'(busy_mask), 64'h0008);
    clear_all();

    // RAW: OR r4 <- r3 waits for writeback of r3
    drive_uop(10'h001, 4'd1, 1, 4'd2, 1, 4'd3, 1, 64'h2000); tick();
    drive_uop(10'h002, 4'd3, 1, 4'd0, 0, 4'd4, 1, 64'h2004); tick();
    idle();
    repeat (3) tick();
    check("or_held", 64'(alu_enable), 64'd0);
    wb_valid = 1; wb_dst = 4'd3; tick();
    idle();
    check("or_rd1", 64'(rf_rd1), 64'd3);
    tick();
    check("or_issue", 64'(alu_enable), 64'd1);
    check("or_opcode", 64'(alu_opcode), 64'h002);
    clear_all();

    // Fill under mem_blocked, fifth push ignored, then drain in order
    mem_blocked = 1;
    for (int k = 0; k < 5; k++) begin
      drive_uop(10'(16 + k), 4'd0, 0, 4'd0, 0, 4'(6 + k), 1, 64'(32'h3000 + k));
      tick();
    end
    idle();
    check("full_ready", 64'(in_ready), 64'd0);
    mem_blocked = 0;
    for (int k = 0; k < 5; k++) tick();
    check("drain_last", 64'(alu_imm), 64'h3003);
    clear_all();

    // Branch flush with same-cycle push
    mem_blocked = 1;
    for (int k = 0; k < 3; k++) begin
      drive_uop(10'(32 + k), 4'd0, 0, 4'd0, 0, 4'd0, 0, 64'(32'h4000 + k)); tick();
    end
    drive_uop(10'h3f, 4'd0, 0, 4'd0, 0, 4'd0, 0, 64'h4100);
    branch_taken = 1; branch_target = 64'h400100; tick();
    idle(); mem_blocked = 0;
    check("br_redirect", 64'(redirect), 64'd1);
    check("br_rip", redirect_rip, 64'h400100);
    check("br_empty", 64'(in_ready), 64'd1);
    tick();
    check("br_pulse_end", 64'(redirect), 64'd0);
    check("br_no_issue", 64'(alu_enable), 64'd0);
    // Back-to-back branches
    branch_taken = 1; branch_target = 64'h500; tick();
    branch_taken = 1; branch_target = 64'h600; tick();
    check("br2_rip", redirect_rip, 64'h600);
    idle(); tick();
    clear_all();

    // Issue of dst=5 coincides with writeback of r5: set wins
    drive_uop(10'h007, 4'd0, 0, 4'd0, 0, 4'd5, 1, 64'h5000); tick();
    idle(); wb_valid = 1; wb_dst = 4'd5; tick();
    idle();
    check("set_wins", 64'(busy_mask[5]), 64'd1);
    clear_all();

    // Mid-stream async reset with the FIFO half full
    drive_uop(10'h009, 4'd0, 0, 4'd0, 0, 4'd10, 1, 64'h6000); tick();
    idle(); tick();
    mem_blocked = 1;
    drive_uop(10'h00a, 4'd1, 1, 4'd0, 0, 4'd11, 1, 64'h6100); tick();
    drive_uop(10'h00b, 4'd2, 1, 4'd0, 0, 4'd12, 1, 64'h6200); tick();
    idle();
    reset_n = 0;
    #1;
    check("mid_rst_ready", 64'(in_ready), 64'd1);
    check("mid_rst_en", 64'(alu_enable), 64'd0);
    check("mid_rst_busy", 64'(busy_mask), 64'd0);
    check("mid_rst_rd1", 64'(rf_rd1), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1; mem_blocked = 0;

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(0, 99) < 60)
        drive_uop(10'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                  4'($urandom), 1'($urandom), {$urandom, $urandom});
      wb_valid = 1'($urandom_range(0, 99) < 50);
      wb_dst   = 4'($urandom);
      mem_blocked = 1'($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 99) < 4) begin
        branch_taken  = 1;
        branch_target = {$urandom, $urandom};
      end
      tick();
    end
    clear_all();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
